ram_port_arbiter: RTL

- Two-requester front end for the single-port command RAM, which takes a 10-bit command word: 2-bit opcode plus 8-bit field.
- Accepts whole read or write transactions from two requesters and arbitrates between them round-robin.
- Serialises each transaction into the RAM command sequence: 00 addr-write, 01 data-write, 10 addr-read, 11 read.
- Returns read data to the owning requester, with a watchdog on the RAM's tx_valid.

---
 rtl/ram_port_arbiter_if.sv | 22 ++
 rtl/ram_port_arbiter.sv | 125 ++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter_if.sv
// Requester-side handshake bundle for ram_port_arbiter.
// master = requester, slave = arbiter.
interface ram_port_arbiter_if #(
  parameter int ADDR_SIZE = 8
);
  logic                 req;
  logic                 we;
  logic [ADDR_SIZE-1:0] addr;
  logic [7:0]           wdata;
  logic                 gnt;
  logic                 rsp_valid;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rsp_valid
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rsp_valid
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin front end that serialises two requesters' read/write transactions
// into the single-port command RAM protocol, with a watchdog on read data.
module ram_port_arbiter #(
  parameter int ADDR_SIZE = 8,
  parameter int TIMEOUT   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  ram_port_arbiter_if.slave    p0,
  ram_port_arbiter_if.slave    p1,
  output logic                 rsp_err,
  output logic [7:0]           rdata,
  output logic                 busy,
  output logic [ADDR_SIZE+1:0] ram_din,
  output logic                 ram_rx_valid,
  input  logic [7:0]           ram_dout,
  input  logic                 ram_tx_valid
);

  typedef enum logic [2:0] {
    IDLE, W_ADDR, W_DATA, R_ADDR, R_CMD, R_WAIT
  } state_t;

  localparam logic [3:0] WD_LAST = 4'(TIMEOUT - 1);

  state_t               state;
  logic                 last_owner;
  logic                 owner;
  logic [7:0]           wdata_q;
  logic [3:0]           wd_cnt;
  logic [1:0]           rsp_valid_q;
  logic [1:0]           grant;
  logic                 sel;
  logic                 sel_we;
  logic [ADDR_SIZE-1:0] sel_addr;
  logic [7:0]           sel_wdata;

  // Grant only while idle; on contention the port that did not go last wins.
  always_comb begin
    grant = 2'b00;
    if (state == IDLE) begin
      if (p0.req && (!p1.req || last_owner)) grant = 2'b01;
      else if (p1.req)                       grant = 2'b10;
    end
  end

  assign sel       = grant[1];
  assign sel_we    = sel ? p1.we    : p0.we;
  assign sel_addr  = sel ? p1.addr  : p0.addr;
  assign sel_wdata = sel ? p1.wdata : p0.wdata;

  assign p0.gnt       = grant[0];
  assign p1.gnt       = grant[1];
  assign p0.rsp_valid = rsp_valid_q[0];
  assign p1.rsp_valid = rsp_valid_q[1];
  assign busy         = (state != IDLE);

  // Command word is registered together with the state it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last_owner   <= 1'b1;
      rsp_valid_q  <= 2'b00;
      rsp_err      <= 1'b0;
      rdata        <= 8'h00;
      ram_din      <= '0;
      ram_rx_valid <= 1'b0;
    end else begin
      rsp_valid_q <= 2'b00;
      case (state)
        IDLE: begin
          if (|grant) begin
            owner        <= sel;
            last_owner   <= sel;
            wdata_q      <= sel_wdata;
            ram_rx_valid <= 1'b1;
            if (sel_we) begin
              ram_din <= {2'b00, sel_addr};
              state   <= W_ADDR;
            end else begin
              ram_din <= {2'b10, sel_addr};
              state   <= R_ADDR;
            end
          end
        end
        W_ADDR: begin
          ram_din <= {2'b01, wdata_q};
          state   <= W_DATA;
        end
        W_DATA: begin
          ram_din      <= '0;
          ram_rx_valid <= 1'b0;
          state        <= IDLE;
        end
        R_ADDR: begin
          ram_din <= {2'b11, {ADDR_SIZE{1'b0}}};
          state   <= R_CMD;
        end
        R_CMD: begin
          ram_din      <= '0;
          ram_rx_valid <= 1'b0;
          wd_cnt       <= 4'd0;
          state        <= R_WAIT;
        end
        R_WAIT: begin
          if (ram_tx_valid) begin
            rdata              <= ram_dout;
            rsp_err            <= 1'b0;
            rsp_valid_q[owner] <= 1'b1;
            state              <= IDLE;
          end else if (wd_cnt == WD_LAST) begin
            rdata              <= 8'h00;
            rsp_err            <= 1'b1;
            rsp_valid_q[owner] <= 1'b1;
            state              <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
